// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register index/word types,
// and the soft-clear sequencer state encoding.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/reg_clear_seq.sv
// Soft-clear sequencer: walks indices 1..DEPTH-1 issuing one clear strobe
// per cycle; requests arriving while a clear is running are ignored.
module reg_clear_seq #(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_req,
  output logic              o_clr_accept,
  output logic              o_busy,
  output logic              o_clr_stb,
  output logic [ADDR_W-1:0] o_clr_idx
);
  import cpu_pkg::*;

  rf_state_e         r_state;
  rf_state_e         w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RF_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Index 0 is hardwired, so the walk starts at 1 and the last strobe
  // (all-ones index) wraps the counter back to 0 on the way to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    o_clr_accept = 1'b0;
    o_clr_stb    = 1'b0;
    case (r_state)
      RF_IDLE: begin
        if (i_clr_req) begin
          o_clr_accept = 1'b1;
          w_state_next = RF_CLEAR;
          w_idx_next   = ADDR_W'(1);
        end
      end
      RF_CLEAR: begin
        o_clr_stb  = 1'b1;
        w_idx_next = r_idx + ADDR_W'(1);
        if (r_idx == '1) begin
          w_state_next = RF_IDLE;
        end
      end
      default: begin
        w_state_next = RF_IDLE;
      end
    endcase
  end

  assign o_busy    = (r_state == RF_CLEAR);
  assign o_clr_idx = r_idx;

endmodule

// File: rtl/reg_file.sv
// 2-read/1-write register file with hardwired zero register and soft-clear.
// Optional same-cycle write forwarding is enabled by REGFILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);
  import cpu_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;

  logic              w_clr_accept;
  logic              w_busy;
  logic              w_clr_stb;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wr_nonzero;
  logic              w_wr_accept;
  logic              w_wr_discard;
  logic              r_wr_drop;
  logic [DATA_W-1:0] w_rd [NREGS];
  logic [DATA_W-1:0] w_bus_a;
  logic [DATA_W-1:0] w_bus_b;

  reg_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr_req    (clr_req),
    .o_clr_accept (w_clr_accept),
    .o_busy       (w_busy),
    .o_clr_stb    (w_clr_stb),
    .o_clr_idx    (w_clr_idx)
  );

  // A clear accepted this cycle outranks a simultaneous write.
  assign w_wr_nonzero = (wr_addr != ADDR_W'(REG_ZERO));
  assign w_wr_accept  = wr_en && w_wr_nonzero && !w_busy && !w_clr_accept;
  assign w_wr_discard = wr_en && w_wr_nonzero && (w_busy || w_clr_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_wr_discard;
    end
  end

  assign w_rd[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_clr_stb && (w_clr_idx == ADDR_W'(gi))) begin
          r_q <= '0;
        end else if (w_wr_accept && (wr_addr == ADDR_W'(gi))) begin
          r_q <= wr_data;
        end
      end
      assign w_rd[gi] = r_q;
    end
  endgenerate

  always_comb begin
    w_bus_a = w_rd[rs_addr];
    w_bus_b = w_rd[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_accept && (wr_addr == rs_addr)) begin
      w_bus_a = wr_data;
    end
    if (w_wr_accept && (wr_addr == rt_addr)) begin
      w_bus_b = wr_data;
    end
`endif
  end

  assign busA    = w_bus_a;
  assign busB    = w_bus_b;
  assign busy    = w_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: doc/reg_file.md
# reg_file

Two-read/one-write 32×32 general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU and drives its `busA`/`busB` operands.
- Takes ALU results, or load data muxed outside, back through its write port at the clock edge.
- Provides a sequenced soft-clear so software and testbenches can zero the file without asserting global reset.

## Interface
- `DATA_W`, 32, register and bus width
- `ADDR_W`, 5, register index width; depth is 2**ADDR_W

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rs_addr`  in  ADDR_W  read port A index
- `rt_addr`  in  ADDR_W  read port B index
- `busA`  out  DATA_W  read port A data
- `busB`  out  DATA_W  read port B data
- `wr_en`  in  1  write request
- `wr_addr`  in  ADDR_W  write index
- `wr_data`  in  DATA_W  write data
- `clr_req`  in  1  soft-clear request, single-cycle pulse or level
- `busy`  out  1  soft-clear in progress
- `wr_drop`  out  1  registered pulse: the previous cycle's write was discarded

## Operation
- Reads are combinational. `busA = R[rs_addr]` and `busB = R[rt_addr]`, with no clock involvement.
- Register 0 always reads 0. Writes to index 0 are discarded silently and do not raise `wr_drop`.
- Write: when `wr_en` is high, not `busy`, and no `clr_req` is accepted this cycle, `R[wr_addr] <= wr_data` at the rising edge.
- Soft-clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR when `clr_req` is high. The clear index is loaded with 1.
  - In CLEAR, each cycle sets `R[idx] <= 0` and `idx <= idx + 1`.
  - Leaving CLEAR: after clearing index 31, go to IDLE. The index wraps to 0 and is not used again.
  - `clr_req` is ignored while in CLEAR; there is no restart.
- `busy` is high exactly while in CLEAR, for 31 cycles.
- Simultaneous `clr_req` and `wr_en` in IDLE: the clear wins, the write is discarded, and `wr_drop` = 1 next cycle.
- `wr_en` high while `busy`: the write is discarded, and `wr_drop` = 1 next cycle.
- Reads during CLEAR return current contents, which may be partially cleared. No stall is generated; the controller must hold the pipeline on `busy`.
- Reset (`rst_n` low): all registers, FSM, index, and `wr_drop` go to 0 immediately, without waiting for a clock edge.
  - Reset during CLEAR aborts the clear; the file is already zero.
  - After reset, `busA` = `busB` = 0, `busy` = 0, `wr_drop` = 0.

## Timing
- Read latency: 0 cycles, combinational from address to bus.
- Write latency: the value is visible on read ports after the rising edge that accepts it.
- A same-cycle read of the write address returns the old value unless the bypass is enabled (see Configuration).
- Soft-clear: `clr_req` is sampled at edge N. `busy` is high from N until edge N+31; `busy` = 0 after N+31, and all registers are 0 at that point.
- `wr_drop`: registered, high for one cycle after the edge that discarded the write.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: if `wr_en` is high, `busy` = 0, no `clr_req` is accepted, `wr_addr` ≠ 0, and `wr_addr` equals `rs_addr` or `rt_addr`, then the matching bus returns `wr_data` combinationally in the same cycle.
- Not defined: there is no forwarding, and the old contents are read until the edge.
- Bypass never forwards dropped writes, and never forwards writes to index 0.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_W` and `ADDR_W` defaults
  - the `reg_idx_t`/`word_t` typedefs
  - the FSM state enum (`RF_IDLE`, `RF_CLEAR`)
  - `REG_ZERO` = 0
- Sub-module `reg_clear_seq`: the FSM, clear index counter, `busy`, and per-cycle clear strobe/index.
- The storage array and read/bypass muxing stay in `reg_file`.

## Test plan
- Reset then read: after `rst_n` deasserts, read all 32 indices on both ports → every value is 0; `busy` = 0, `wr_drop` = 0.
- Write/readback: write 0xDEADBEEF to R5 and 0x00000007 to R6, then read `rs`=5, `rt`=6 → `busA` = 0xDEADBEEF, `busB` = 0x7. Write 0x1234 to R0, then read R0 → 0, and `wr_drop` = 0.
- Same-cycle read of write address: R9 = 0x11, then write 0x22 to R9 while reading R9 → `busA` = 0x11 without the bypass and 0x22 with `REGFILE_BYPASS_EN`. In both builds, `busA` = 0x22 after the edge.
- Soft-clear: fill R1–R31 with index×0x01010101, then pulse `clr_req` → `busy` is high for exactly 31 cycles. Every register reads 0 afterwards. A second `clr_req` at cycle 10 of the clear has no effect on the duration.
- Collisions: `clr_req` and `wr_en` (R3 ← 0xAA) in the same cycle → `wr_drop` = 1 next cycle and R3 = 0 after the clear. `wr_en` during `busy` → `wr_drop` pulses and the register is not written.
- Reset mid-clear: assert `rst_n` low at clear cycle 12 → `busy` = 0 immediately, and all registers read 0. A fresh `clr_req` after release runs a full 31 cycles.
